// File: rtl/binary_to_gray_counter.sv
// Up/down binary counter with registered reflected-Gray output and a one-cycle wrap pulse.
// Gray is encoded from the next count so bin and gray always describe the same value.
module binary_to_gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;

  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Load beats counting; wrap only flags a genuine modulo step.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (load) begin
      cnt_nxt = load_bin;
    end else if (en) begin
      if (up) begin
        cnt_nxt  = cnt + CNT_ONE;
        wrap_nxt = &cnt;
      end else begin
        cnt_nxt  = cnt - CNT_ONE;
        wrap_nxt = ~|cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= CNT_ZERO;
      gray <= CNT_ZERO;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      gray <= encode(cnt_nxt);
      wrap <= wrap_nxt;
    end
  end

  assign bin = cnt;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// Directed and randomized checks of binary_to_gray_counter (WIDTH=4) against hand values and a small model.
module tb_binary_to_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  binary_to_gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit u, input bit l, input logic [W-1:0] lb);
    rst_n    = r;
    en       = e;
    up       = u;
    load     = l;
    load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int b, input int g, input int w);
    check({tag, "_bin"}, 32'(bin), 32'(b));
    check({tag, "_gray"}, 32'(gray), 32'(g));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  function automatic int gray_of(input int b);
    int g;
    g = 0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) g |= ((b >> i) & 1) << i;
      else            g |= (((b >> (i + 1)) ^ (b >> i)) & 1) << i;
    end
    return g;
  endfunction

  initial begin
    logic [3:0] gseq [16];
    int m_bin, m_wrap, tmp;
    logic [W-1:0] prev_gray;
    bit r, e, u, l;
    logic [W-1:0] lb;

    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Test 1: reset then full up sequence with wrap
    tick(0, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    expect_out("reset_hold", 0, 0, 0);
    for (int k = 1; k < 16; k++) begin
      tick(1, 1, 1, 0, 0);
      check("up_seq_bin", 32'(bin), 32'(k));
      check("up_seq_gray", 32'(gray), 32'(gseq[k]));
      check("up_seq_wrap", 32'(wrap), 0);
    end
    tick(1, 1, 1, 0, 0);
    expect_out("up_wrap", 0, 0, 1);
    tick(1, 0, 1, 0, 0);
    expect_out("wrap_one_cycle", 0, 0, 0);

    // Test 2: underflow from reset
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    expect_out("down_wrap", 4'hF, 4'b1000, 1);
    tick(1, 1, 0, 0, 0);
    expect_out("down_next", 4'hE, 4'b1001, 0);

    // Test 3: load beats en
    tick(1, 1, 1, 1, 4'b1010);
    expect_out("load", 4'hA, 4'b1111, 0);
    tick(1, 1, 1, 0, 0);
    expect_out("after_load", 4'hB, 4'b1110, 0);

    // Load of all-ones with en up must not wrap; the following step does
    tick(1, 1, 1, 1, 4'hF);
    expect_out("load_ones", 4'hF, 4'b1000, 0);
    tick(1, 1, 1, 0, 0);
    expect_out("load_ones_step", 0, 0, 1);
    tick(1, 1, 0, 1, 4'h0);
    expect_out("load_zero_down", 0, 0, 0);

    // Test 4: hold with en=0, then one down step
    tick(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(1, 1, 1, 0, 0);
    expect_out("count5", 5, 4'b0111, 0);
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, k[0], 0, 0);
      expect_out("hold", 5, 4'b0111, 0);
    end
    tick(1, 1, 0, 0, 0);
    expect_out("hold_down", 4, 4'b0110, 0);

    // Test 6: reset mid-count
    tick(0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) tick(1, 1, 1, 0, 0);
    expect_out("count12", 4'hC, 4'b1010, 0);
    tick(0, 1, 1, 0, 0);
    expect_out("mid_reset", 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    expect_out("resume", 1, 1, 0);

    // Test 5: random stimulus against a reference model
    m_bin  = 1;
    m_wrap = 0;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 99) != 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) != 0;
      lb = W'($urandom_range(0, (1 << W) - 1));
      prev_gray = gray;
      if (!r) begin
        m_bin = 0; m_wrap = 0;
      end else if (l) begin
        m_bin = int'(lb); m_wrap = 0;
      end else if (e) begin
        tmp    = u ? m_bin + 1 : m_bin - 1;
        m_wrap = (tmp < 0 || tmp >= (1 << W)) ? 1 : 0;
        m_bin  = (tmp + (1 << W)) % (1 << W);
      end else begin
        m_wrap = 0;
      end
      tick(r, e, u, l, lb);
      expect_out("rand", m_bin, gray_of(m_bin), m_wrap);
      if (r && !l && e)
        check("rand_hamming", 32'($countones(gray ^ prev_gray)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
